// File: rtl/button_debounce_edge.sv
// Active-low push-button front end: 2-flop synchroniser, press/release debounce,
// registered edge pulses and long-press auto-repeat.
module button_debounce_edge #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000,
  parameter int CNT_W           = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic long_press
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic             sync_a, sync_q, p;
  logic [CNT_W-1:0] dcnt, dcnt_nx;
  logic [CNT_W-1:0] hcnt, hcnt_nx;
  logic [CNT_W-1:0] rcnt, rcnt_nx;
  logic             level_nx, press_nx, release_nx, repeat_nx, long_nx;

  // Synchroniser idles at 1 so a reset reads as "released".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      sync_a <= button;
      sync_q <= sync_a;
    end
  end

  assign p = ~sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      dcnt          <= '0;
      hcnt          <= '0;
      rcnt          <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      state         <= state_nx;
      dcnt          <= dcnt_nx;
      hcnt          <= hcnt_nx;
      rcnt          <= rcnt_nx;
      btn_level     <= level_nx;
      press_pulse   <= press_nx;
      release_pulse <= release_nx;
      repeat_pulse  <= repeat_nx;
      long_press    <= long_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    dcnt_nx    = dcnt;
    hcnt_nx    = hcnt;
    rcnt_nx    = rcnt;
    long_nx    = long_press;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    repeat_nx  = 1'b0;

    case (state)
      IDLE: begin
        if (p) begin
          state_nx = PRESS_WAIT;
          dcnt_nx  = '0;
        end
      end

      PRESS_WAIT: begin
        if (!p) begin
          state_nx = IDLE;
          dcnt_nx  = '0;
        end else if (dcnt == DEB_LAST) begin
          state_nx = PRESSED;
          dcnt_nx  = '0;
          hcnt_nx  = '0;
          rcnt_nx  = '0;
          press_nx = 1'b1;
        end else begin
          dcnt_nx = dcnt + 1'b1;
        end
      end

      PRESSED: begin
        // hcnt saturates at HOLD; from then on rcnt paces the repeats.
        if (hcnt == HOLD_LAST) begin
          hcnt_nx   = HOLD_MAX;
          rcnt_nx   = '0;
          repeat_nx = 1'b1;
          long_nx   = 1'b1;
        end else if (hcnt == HOLD_MAX) begin
          if (rcnt == REP_LAST) begin
            rcnt_nx   = '0;
            repeat_nx = 1'b1;
          end else begin
            rcnt_nx = rcnt + 1'b1;
          end
        end else begin
          hcnt_nx = hcnt + 1'b1;
        end
        if (!p) begin
          state_nx = RELEASE_WAIT;
          dcnt_nx  = '0;
        end
      end

      RELEASE_WAIT: begin
        if (p) begin
          state_nx = PRESSED;
          dcnt_nx  = '0;
        end else if (dcnt == DEB_LAST) begin
          state_nx   = IDLE;
          dcnt_nx    = '0;
          hcnt_nx    = '0;
          rcnt_nx    = '0;
          long_nx    = 1'b0;
          release_nx = 1'b1;
        end else begin
          dcnt_nx = dcnt + 1'b1;
        end
      end

      default: begin
        state_nx = IDLE;
        dcnt_nx  = '0;
        hcnt_nx  = '0;
        rcnt_nx  = '0;
        long_nx  = 1'b0;
      end
    endcase

    level_nx = (state_nx == PRESSED) || (state_nx == RELEASE_WAIT);
  end

endmodule
